// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_fifo                                                 |
// | Description : UART receiver (2-FF synchronised RXD, mid-bit sampling)      |
// |               feeding a first-word fall-through receive FIFO with          |
// |               per-entry frame/parity error flags and a sticky overrun.     |
// | Config macro: UART_RX_PARITY_EN - adds one parity bit per frame and the    |
// |               parity check; without it rx_parity_err is held at 0.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DATA_BITS        = 8,
  parameter int BAUD_PERIOD_BITS = 16,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [BAUD_PERIOD_BITS-1:0]   baud_rate_period_m1,
  input  logic                          parity_odd,
  input  logic                          RXD,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic                          flush,
  input  logic                          clear_overrun,
  output logic                          overrun
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int               IDX_W    = $clog2(FIFO_DEPTH);
  localparam int               ENTRY_W  = DATA_BITS + 2;
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Receiver state machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser and start-edge detection
  // --------------------------------------------------------------------------
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       hist_q,  hist_d;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       start_edge;

  // Synchroniser chain; settle tracks when sync2 holds a real line sample,
  // armed records that a genuine idle-high level has been seen since reset.
  always_comb begin
    sync1_d  = RXD;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & sync2_q);
  end

  // A falling edge only counts once the line was really seen high beforehand.
  assign start_edge = armed_q & hist_q & ~sync2_q;

  // Synchroniser registers; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      hist_q   <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  state_t                      state_q, state_d;
  logic [BAUD_PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]                  bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]        shift_q, shift_d;
  logic                        frame_err_q, frame_err_d;
  logic                        push_pend_q, push_pend_d;
  logic                        bit_tick;
  logic [BAUD_PERIOD_BITS-1:0] half_period;
  logic                        entry_perr;

  assign bit_tick    = (cnt_q == baud_rate_period_m1);
  assign half_period = baud_rate_period_m1 >> 1;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign entry_perr = par_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign entry_perr        = 1'b0;
`endif

  // Next-state logic: mid-bit sampling, LSB-first shift, stop-bit check.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    push_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (!enable) begin
      // Abandon any partial frame; a completed frame already pending still pushes.
      state_d   = S_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            cnt_d   = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (cnt_q == half_period) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A line already back high mid start bit was a glitch.
            state_d   = sync2_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            cnt_d   = '0;
            shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            cnt_d     = '0;
            par_err_d = ((^shift_q) ^ sync2_q) != parity_odd;
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick) begin
            cnt_d       = '0;
            frame_err_d = ~sync2_q;
            push_pend_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Receiver registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      push_pend_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      push_pend_q <= push_pend_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic               overrun_q, overrun_d;
  logic [PTR_W-1:0]   count;
  logic               full;
  logic               not_empty;
  logic               pop;
  logic               push;
  logic               do_write;
  logic               drop;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] new_entry;

  assign count     = wr_q - rd_q;
  assign full      = (count == DEPTH_P);
  assign not_empty = (count != '0);
  assign pop       = not_empty & rx_ready;
  assign push      = push_pend_q & ~flush;
  // A pop in the same cycle frees the slot the new entry lands in.
  assign do_write  = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign new_entry = {frame_err_q, entry_perr, shift_q};
  assign head      = mem_q[rd_q[IDX_W-1:0]];

  // FIFO pointer/storage update; flush beats any push or pop in the same cycle.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_write) begin
        mem_d[wr_q[IDX_W-1:0]] = new_entry;
        wr_d                   = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
    end
    // Setting the sticky flag takes priority over clearing it.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // FIFO registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      overrun_q <= overrun_d;
    end
  end

  // Head outputs read as zero whenever the FIFO is empty.
  assign rx_valid      = not_empty;
  assign rx_data       = not_empty ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = not_empty & head[DATA_BITS];
  assign rx_frame_err  = not_empty & head[DATA_BITS+1];
  assign rx_count      = count;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo                                              |
// | Description : Self-checking bench for uart_rx_fifo: directed vector table, |
// |               hand-written corner sequences and random frames checked      |
// |               against a queue-based receive model.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int DB    = 8;
  localparam int BPB   = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b1;
  logic [BPB-1:0] baud_rate_period_m1 = 16'd15;
  logic           parity_odd = 1'b0;
  logic           RXD = 1'b1;
  logic [DB-1:0]  rx_data;
  logic           rx_frame_err;
  logic           rx_parity_err;
  logic           rx_valid;
  logic           rx_ready = 1'b0;
  logic [2:0]     rx_count;
  logic           flush = 1'b0;
  logic           clear_overrun = 1'b0;
  logic           overrun;

  uart_rx_fifo #(
    .DATA_BITS(DB),
    .BAUD_PERIOD_BITS(BPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .baud_rate_period_m1(baud_rate_period_m1),
    .parity_odd(parity_odd),
    .RXD(RXD),
    .rx_data(rx_data),
    .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_count(rx_count),
    .flush(flush),
    .clear_overrun(clear_overrun),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Receive model: what the FIFO should hold, in order, plus the sticky flag.
  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } entry_t;
  entry_t model_q[$];
  logic   model_ovr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         per;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_perr(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    return ((^d) ^ p) != parity_odd;
`else
    return 1'b0 & p & d[0];
`endif
  endfunction

  task automatic send_bit(input logic b, input int per);
    RXD = b;
    repeat (per + 1) tick();
  endtask

  // Serialise one frame onto RXD and record what the receiver must store.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int per);
    entry_t e;
    baud_rate_period_m1 = BPB'(per);
    send_bit(1'b0, per);
    for (int i = 0; i < DB; i++) send_bit(d[i], per);
`ifdef UART_RX_PARITY_EN
    send_bit(par, per);
`endif
    send_bit(stop, per);
    RXD = 1'b1;
    repeat (6) tick();
    e.data = d;
    e.ferr = ~stop;
    e.perr = exp_perr(d, par);
    if (model_q.size() == DEPTH) model_ovr = 1'b1;
    else model_q.push_back(e);
  endtask

  task automatic check_head(input string tag);
    check({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
    check({tag, "_valid"}, 32'(rx_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check({tag, "_data"}, 32'(rx_data), 32'(model_q[0].data));
      check({tag, "_ferr"}, 32'(rx_frame_err), 32'(model_q[0].ferr));
      check({tag, "_perr"}, 32'(rx_parity_err), 32'(model_q[0].perr));
    end else begin
      check({tag, "_data0"}, 32'(rx_data), 32'h0);
    end
    check({tag, "_ovr"}, 32'(overrun), 32'(model_ovr));
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, stop: 1'b1, par: 1'b0, per: 15};
    tbl[1] = '{data: 8'h3C, stop: 1'b0, par: 1'b1, per: 15};
    tbl[2] = '{data: 8'h00, stop: 1'b1, par: 1'b1, per: 3};
    tbl[3] = '{data: 8'hFF, stop: 1'b1, par: 1'b0, per: 7};
    tbl[4] = '{data: 8'h5A, stop: 1'b0, par: 1'b0, per: 4};

    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_count", 32'(rx_count), 32'h0);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_ferr", 32'(rx_frame_err), 32'h0);
    check("rst_perr", 32'(rx_parity_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Directed vector table: one frame, check head, pop, check empty
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].par, tbl[i].per);
      check_head("tbl");
      pop_one();
      check("tbl_empty", 32'(rx_count), 32'h0);
    end

    // Short low glitch is rejected at the start-bit sample
    baud_rate_period_m1 = 16'd15;
    RXD = 1'b0;
    repeat (4) tick();
    RXD = 1'b1;
    repeat (40) tick();
    check("glitch_count", 32'(rx_count), 32'h0);
    check("glitch_valid", 32'(rx_valid), 32'h0);
    send_frame(8'hC3, 1'b1, 1'b0, 15);
    check_head("post_glitch");
    pop_one();

    // Overflow: five frames into a 4-deep FIFO with nothing popped
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 3);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_count", 32'(rx_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check_head("ovr_head");
      pop_one();
    end
    check("ovr_drained", 32'(rx_count), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    model_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Flush empties the FIFO next cycle
    send_frame(8'h11, 1'b1, 1'b0, 3);
    send_frame(8'h22, 1'b1, 1'b0, 3);
    check("pre_flush_count", 32'(rx_count), 32'h2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_q.delete();
    check("flush_count", 32'(rx_count), 32'h0);
    check("flush_valid", 32'(rx_valid), 32'h0);

    // Enable low mid-frame drops the partial frame but keeps FIFO contents
    send_frame(8'h66, 1'b1, 1'b0, 7);
    baud_rate_period_m1 = 16'd7;
    send_bit(1'b0, 7);
    send_bit(1'b1, 7);
    send_bit(1'b0, 7);
    enable = 1'b0;
    tick();
    RXD = 1'b1;
    enable = 1'b1;
    repeat (120) tick();
    check_head("en_low");
    pop_one();

    // Reset during data bit 3 of 0x55: nothing pushed, next frame clean
    baud_rate_period_m1 = 16'd15;
    send_bit(1'b0, 15);
    for (int i = 0; i < 3; i++) send_bit(1'(i % 2 == 0), 15);
    RXD = 1'b0;
    repeat (8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    RXD = 1'b1;
    repeat (200) tick();
    model_q.delete();
    model_ovr = 1'b0;
    check("rstmid_count", 32'(rx_count), 32'h0);
    check("rstmid_valid", 32'(rx_valid), 32'h0);
    send_frame(8'hAA, 1'b1, 1'b0, 15);
    check_head("rstmid_next");
    pop_one();

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x07 has three ones, parity bit 1 makes four -> error
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 15);
    check("par_err1", 32'(rx_parity_err), 32'h1);
    check_head("par1");
    pop_one();
    send_frame(8'h07, 1'b1, 1'b0, 15);
    check("par_err0", 32'(rx_parity_err), 32'h0);
    check_head("par0");
    pop_one();
`endif

    // Random frames against the model, with random partial draining
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       st;
      logic       pb;
      int         per;
      int         k;
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) != 0);
      pb  = 1'($urandom_range(0, 1));
      per = $urandom_range(3, 12);
      parity_odd = 1'($urandom_range(0, 1));
      send_frame(d, st, pb, per);
      check_head("rnd");
      k = $urandom_range(0, model_q.size());
      for (int j = 0; j < k; j++) begin
        pop_one();
        check_head("rnd_pop");
      end
      if (model_ovr && $urandom_range(0, 1) == 1) begin
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        model_ovr = 1'b0;
        check("rnd_clr", 32'(overrun), 32'h0);
      end
    end
    while (model_q.size() != 0) begin
      check_head("drain");
      pop_one();
    end
    // Popping an empty FIFO must not wrap the count
    pop_one();
    check("empty_pop_count", 32'(rx_count), 32'h0);
    check("empty_pop_valid", 32'(rx_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-002 SHALL have parameter BAUD_PERIOD_BITS, default 16, meaning width of baud period input and bit counter.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning RX FIFO entries (power of 2, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  receiver enable; low forces FSM to S_IDLE.
REQ-007 SHALL have port baud_rate_period_m1  input  BAUD_PERIOD_BITS  clocks per bit minus 1 (min 3).
REQ-008 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN).
REQ-009 SHALL have port RXD  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data  output  DATA_BITS  FIFO head data (first-word fall-through).
REQ-011 SHALL have port rx_frame_err / rx_parity_err  output  1 each  error flags of FIFO head entry.
REQ-012 SHALL have port rx_valid / rx_ready  output / input  1 each  head handshake; pop = rx_valid & rx_ready.
REQ-013 SHALL have port rx_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-014 SHALL have ports flush / clear_overrun  input  1 each, and overrun  output  1  sticky overflow flag.

Function
REQ-015 SHALL pass RXD through 2-FF synchronizer plus 1 history FF; start edge = history high & synchronized low.
REQ-016 SHALL implement FSM S_IDLE, S_START, S_DATA, S_PARITY, S_STOP; S_PARITY skipped when macro absent.
REQ-017 SHALL, in S_IDLE with enable=1 and start edge, clear bit counter and enter S_START.
REQ-018 SHALL sample start bit when bit counter == baud_rate_period_m1>>1; low -> S_DATA, high -> S_IDLE (glitch reject, nothing pushed).
REQ-019 SHALL, after start sample, sample every baud_rate_period_m1+1 clocks; data LSB first, DATA_BITS samples in S_DATA.
REQ-020 SHALL in S_STOP sample one stop bit; rx_frame_err of entry = (stop sample == 0); then S_IDLE, ready for next edge same cycle-after.
REQ-021 SHALL push {frame_err, parity_err, data} into FIFO on the cycle after stop sample; rx_valid visible the following cycle.
REQ-022 SHALL, on push with FIFO full and no simultaneous pop, drop the new entry and set overrun; full with pop in same cycle accepts push.
REQ-023 SHALL keep overrun set until clear_overrun; simultaneous set and clear -> set wins.
REQ-024 SHALL, on flush, empty FIFO (rx_count=0, rx_valid=0) next cycle; a push in the same cycle is discarded; FSM unaffected.
REQ-025 SHALL, on enable low mid-frame, return to S_IDLE next cycle and discard partial frame; FIFO contents retained.
REQ-026 SHALL treat pop with rx_valid=0 as no-op; rx_count never wraps.
REQ-027 SHALL use read/write pointers of $clog2(FIFO_DEPTH)+1 bits wrapping modulo 2*FIFO_DEPTH.

Reset
REQ-028 SHALL on reset_n=0 at clk edge: FSM S_IDLE, counters 0, synchronizer FFs 1, FIFO empty, rx_valid=0, rx_data=0, error flags 0, overrun=0, rx_count=0.
REQ-029 SHALL discard any in-flight frame on reset; first edge after release requires RXD high one cycle before start detect.

Configuration
REQ-030 SHALL, with UART_RX_PARITY_EN defined, sample one parity bit in S_PARITY and set rx_parity_err when XOR(data, parity bit) != parity_odd.
REQ-031 SHALL, without UART_RX_PARITY_EN, omit S_PARITY and parity logic; rx_parity_err tied 0; parity_odd ignored.

Verification
REQ-032 SHALL cover: period_m1=15, 8N1 frame 0xA5, stop=1 -> rx_data=0xA5, rx_valid=1, both err=0, rx_count=1.
REQ-033 SHALL cover: RXD low 4 clocks at period_m1=15 -> no push, FSM back in S_IDLE, rx_count=0.
REQ-034 SHALL cover: frame 0x3C with stop bit 0 -> entry 0x3C, rx_frame_err=1.
REQ-035 SHALL cover: FIFO_DEPTH=4, five frames 0x01..0x05, rx_ready=0 -> heads 0x01..0x04, overrun=1, 0x05 lost.
REQ-036 SHALL cover (macro on): parity_odd=1, data 0x07 with parity bit 1 -> rx_parity_err=1; parity bit 0 -> 0.
REQ-037 SHALL cover: reset_n=0 during data bit 3 of 0x55 -> nothing pushed, next frame 0xAA received correctly.
